multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Multi-cycle control unit for the processor. It sequences each instruction through fetch, decode, execute, memory and writeback states, and handshakes with instruction and data memories that can take variable latency. It produces the same datapath control word as the single-cycle decoder (Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite, PCSelect), plus PC/IR write enables and a halt/resume mechanism. It sits between the instruction register and the datapath muxes.

## Interface
- `MEM_TIMEOUT`, default 16: maximum wait cycles for `imem_ready` or `dmem_ready`. 0 disables the timeout.
- `FENCE_AS_NOP`, default 1: 1 retires FENCE/FENCE.TSO/PAUSE as a no-op. 0 halts on them.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `instr`  in  32  instruction-register contents, valid from DECODE onward.
- `imem_ready`  in  1  instruction fetch complete.
- `dmem_ready`  in  1  data access complete.
- `resume`  in  1  leave HALT (recoverable causes only).
- `imem_req`  out  1  instruction fetch request.
- `dmem_req`  out  1  data access request.
- `ir_write`  out  1  load the IR.
- `pc_write`  out  1  update the PC (datapath gates branches with its compare result).
- `Branch`, `MemRead`, `MemWrite`, `ALUSrc`, `RegWrite`, `PCSelect`  out  1 each  datapath controls.
- `MemtoReg`  out  3  writeback select: 000 ALU, 001 mem, 010 imm, 011 PC+imm, 100 PC+4.
- `ALUOp`  out  2  00 add, 01 branch, 10 funct-decoded, 11 pass/none.
- `halted`  out  1  FSM is in HALT.
- `halt_cause`  out  3  000 none, 001 ECALL, 010 EBREAK, 011 FENCE, 100 illegal, 101 timeout.
- `state`  out  3  current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5.
- **FETCH**
  - `imem_req`=1.
  - On `imem_ready`: pulse `ir_write`, go to DECODE.
  - Otherwise stay and increment the wait counter.
- **DECODE**
  - Classify `instr[6:2]` and latch the class; the latched class holds the control word until the next DECODE.
  - `instr[1:0]`≠11 or an unlisted opcode: go to HALT, cause=illegal.
  - 11100: go to HALT; cause=EBREAK if `instr[20]`=1, else ECALL.
  - 00011: go to WB if `FENCE_AS_NOP`=1, else HALT with cause=FENCE.
  - All other classes: go to EXECUTE.
- **EXECUTE**
  - The control word is driven from the class, with the encodings of the single-cycle decoder.
  - Load/store: go to MEM. Otherwise: go to WB.
- **MEM**
  - `dmem_req`=1, with MemRead or MemWrite per class.
  - Wait for `dmem_ready`, then go to WB.
- **WB**
  - `pc_write`=1.
  - RegWrite=1 for R/I/load/LUI/AUIPC/JAL/JALR.
  - Go to FETCH.
- **HALT**
  - `halted`=1 and all enables are 0.
  - `resume`=1 with cause ECALL, EBREAK or FENCE: go to WB with RegWrite=0 (PC advances), then clear the cause.
  - Illegal and timeout causes are sticky until reset.
- **Wait counter**
  - Cleared on every state entry.
  - With `MEM_TIMEOUT`>0: when the counter reaches `MEM_TIMEOUT`-1 and ready is still 0, go to HALT with cause=timeout.
  - Ready arriving on that same cycle wins; no timeout is taken.
- The control word is 0 (MemtoReg=000, ALUOp=00) in FETCH, DECODE and HALT.

## Timing
- Reset (async assert, sync release):
  - State=FETCH, counter=0, cause=000, class=NOP.
  - All outputs 0 except `imem_req`=1 and `state`=000.
- All control outputs are Moore outputs decoded from registered state and class. `ir_write` is Mealy on `imem_ready` in FETCH.
- Latency with zero memory wait: ALU/branch/jump/U-type 4 cycles, load/store 5 cycles, FENCE-as-NOP 3 cycles.
- Each cycle of memory wait adds exactly 1 cycle.
- `ready` is sampled only in the matching state; stray pulses elsewhere are ignored.
- Reset asserted mid-instruction: next state is FETCH with no `pc_write` and no `RegWrite` pulse.
- `resume` held high across the reset release has no effect (the FSM is not in HALT).

## Structure
- Shared package `ctrl_pkg` holds:
  - state enum
  - opcode constants (01100, 00000, 01000, 11000, 00100, 01101, 00101, 11011, 11001, 00011, 11100)
  - MemtoReg, ALUOp and halt-cause encodings
  - control-word struct
- Sub-module `ctrl_decode`: combinational opcode → {class, control word, legal} map. It is reused by the FSM's DECODE and EXECUTE states.

## Test plan
- ADD, `imem_ready` immediate → states 0,1,2,4. In WB: RegWrite=1, MemtoReg=000, ALUOp=10, `pc_write`=1. Returns to FETCH on cycle 4.
- LW with `dmem_ready` delayed 3 cycles → MEM held 4 cycles with `dmem_req`=1 and MemRead=1. WB has MemtoReg=001. 8 cycles total.
- `MEM_TIMEOUT`=4, `imem_ready` never asserted → HALT after 4 cycles, `halt_cause`=101. `resume` is ignored.
- EBREAK (0x00100073) → HALT with cause=010. `resume` → one WB cycle with `pc_write`=1 and RegWrite=0, then FETCH with cause=000.
- Opcode 0x0000007F (illegal) → HALT, cause=100, sticky. `rst_n` low for 1 cycle → FETCH, all outputs at reset values.
- JAL, with reset asserted in EXECUTE → immediately FETCH. No `pc_write` or `RegWrite` pulse is observed.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types for the multi-cycle control unit: states, opcode classes, encodings, control word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    // instr[6:2] major opcodes (instr[1:0] must be 2'b11)
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_FENCE  = 5'b00011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    typedef enum logic [2:0] {
        M2R_ALU   = 3'b000,
        M2R_MEM   = 3'b001,
        M2R_IMM   = 3'b010,
        M2R_PCIMM = 3'b011,
        M2R_PC4   = 3'b100
    } m2r_t;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10,
        ALU_PASS   = 2'b11
    } aluop_t;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'b000,
        CAUSE_ECALL   = 3'b001,
        CAUSE_EBREAK  = 3'b010,
        CAUSE_FENCE   = 3'b011,
        CAUSE_ILLEGAL = 3'b100,
        CAUSE_TIMEOUT = 3'b101
    } cause_t;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_R, CLS_IMM, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_LUI,
        CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_FENCE, CLS_SYSTEM, CLS_ILLEGAL
    } class_t;

    typedef struct packed {
        logic   branch;
        logic   mem_read;
        logic   mem_write;
        logic   alu_src;
        logic   reg_write;
        logic   pc_select;
        m2r_t   mem_to_reg;
        aluop_t alu_op;
    } ctrl_word_t;

    localparam ctrl_word_t CW_ZERO = '0;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control-unit <-> datapath/memory bundle: IR contents, memory handshakes, control word, status.
// Latency: n/a (wires only).
// Backpressure: imem/dmem req held until the matching ready; master = control FSM, slave = datapath side.
interface multicycle_control_fsm_if;
    import ctrl_pkg::*;

    logic [31:0] instr;
    logic        imem_ready;
    logic        dmem_ready;
    logic        resume;
    logic        imem_req;
    logic        dmem_req;
    logic        ir_write;
    logic        pc_write;
    logic        Branch;
    logic        MemRead;
    logic        MemWrite;
    logic        ALUSrc;
    logic        RegWrite;
    logic        PCSelect;
    m2r_t        MemtoReg;
    aluop_t      ALUOp;
    logic        halted;
    cause_t      halt_cause;
    state_t      state;

    modport master (
        input  instr, imem_ready, dmem_ready, resume,
        output imem_req, dmem_req, ir_write, pc_write,
               Branch, MemRead, MemWrite, ALUSrc, RegWrite, PCSelect,
               MemtoReg, ALUOp, halted, halt_cause, state
    );

    modport slave (
        output instr, imem_ready, dmem_ready, resume,
        input  imem_req, dmem_req, ir_write, pc_write,
               Branch, MemRead, MemWrite, ALUSrc, RegWrite, PCSelect,
               MemtoReg, ALUOp, halted, halt_cause, state
    );
endinterface

// File: rtl/multicycle_control_fsm_decode.sv
// Opcode classifier and class -> control-word map shared by the DECODE and EXECUTE states.
// Latency: combinational.
// Backpressure: none.
// Ports: opcode (instr[6:0]) -> cls_out/legal; cls_in (latched class) -> cw.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  class_t     cls_in,
    output class_t     cls_out,
    output logic       legal,
    output ctrl_word_t cw
);

    always_comb begin
        cls_out = CLS_ILLEGAL;
        if (opcode[1:0] == 2'b11) begin
            case (opcode[6:2])
                OP_R:      cls_out = CLS_R;
                OP_IMM:    cls_out = CLS_IMM;
                OP_LOAD:   cls_out = CLS_LOAD;
                OP_STORE:  cls_out = CLS_STORE;
                OP_BRANCH: cls_out = CLS_BRANCH;
                OP_LUI:    cls_out = CLS_LUI;
                OP_AUIPC:  cls_out = CLS_AUIPC;
                OP_JAL:    cls_out = CLS_JAL;
                OP_JALR:   cls_out = CLS_JALR;
                OP_FENCE:  cls_out = CLS_FENCE;
                OP_SYSTEM: cls_out = CLS_SYSTEM;
                default:   cls_out = CLS_ILLEGAL;
            endcase
        end
        legal = (cls_out != CLS_ILLEGAL);
    end

    // Full control word of the class; the FSM gates the memory and
    // register-write strobes down to the state that owns them.
    always_comb begin
        cw = CW_ZERO;
        case (cls_in)
            CLS_R:      begin cw.alu_op = ALU_FUNCT; cw.reg_write = 1'b1; end
            CLS_IMM:    begin cw.alu_op = ALU_FUNCT; cw.alu_src = 1'b1; cw.reg_write = 1'b1; end
            CLS_LOAD:   begin
                cw.alu_src = 1'b1; cw.mem_read = 1'b1;
                cw.mem_to_reg = M2R_MEM; cw.reg_write = 1'b1;
            end
            CLS_STORE:  begin cw.alu_src = 1'b1; cw.mem_write = 1'b1; end
            CLS_BRANCH: begin cw.branch = 1'b1; cw.alu_op = ALU_BRANCH; end
            CLS_LUI:    begin cw.mem_to_reg = M2R_IMM; cw.alu_op = ALU_PASS; cw.reg_write = 1'b1; end
            CLS_AUIPC:  begin cw.mem_to_reg = M2R_PCIMM; cw.alu_op = ALU_PASS; cw.reg_write = 1'b1; end
            CLS_JAL:    begin
                cw.pc_select = 1'b1; cw.mem_to_reg = M2R_PC4;
                cw.alu_op = ALU_PASS; cw.reg_write = 1'b1;
            end
            CLS_JALR:   begin
                cw.alu_src = 1'b1; cw.pc_select = 1'b1;
                cw.mem_to_reg = M2R_PC4; cw.reg_write = 1'b1;
            end
            default:    cw = CW_ZERO;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control FSM: FETCH/DECODE/EXECUTE/MEM/WB sequencing with HALT, resume and memory timeout.
// Latency: 4 cycles ALU/branch/jump/U-type, 5 load/store, 3 FENCE-as-NOP, +1 per memory wait cycle.
// Backpressure: holds imem_req/dmem_req until ready; after MEM_TIMEOUT cycles without ready it halts.
// Ports: clk, rst_n (async, active-low), bus (master modport: IR, handshakes, control word, status).
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 16,
    parameter bit FENCE_AS_NOP = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_control_fsm_if.master bus
);

    localparam int WAIT_W = 16;

    state_t             state_q;
    class_t             cls_q;
    cause_t             cause_q;
    logic [WAIT_W-1:0]  wait_q;

    class_t             dec_cls;
    logic               dec_legal;
    ctrl_word_t         cw;
    ctrl_word_t         act_cw;
    logic               tmo_hit;
    logic               unused_instr;

    assign unused_instr = ^{bus.instr[31:21], bus.instr[19:7]};

    ctrl_decode u_decode (
        .opcode  (bus.instr[6:0]),
        .cls_in  (cls_q),
        .cls_out (dec_cls),
        .legal   (dec_legal),
        .cw      (cw)
    );

    // Last permitted wait cycle; a ready arriving on this same cycle still wins.
    assign tmo_hit = (MEM_TIMEOUT > 0) && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            cls_q   <= CLS_NOP;
            cause_q <= CAUSE_NONE;
            wait_q  <= '0;
        end else begin
            // Any transition clears the wait counter; only waiting states count up.
            wait_q <= '0;
            case (state_q)
                ST_FETCH: begin
                    if (bus.imem_ready) begin
                        state_q <= ST_DECODE;
                    end else if (tmo_hit) begin
                        state_q <= ST_HALT;
                        cause_q <= CAUSE_TIMEOUT;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                ST_DECODE: begin
                    cls_q <= dec_cls;
                    if (!dec_legal) begin
                        state_q <= ST_HALT;
                        cause_q <= CAUSE_ILLEGAL;
                    end else if (dec_cls == CLS_SYSTEM) begin
                        state_q <= ST_HALT;
                        cause_q <= bus.instr[20] ? CAUSE_EBREAK : CAUSE_ECALL;
                    end else if (dec_cls == CLS_FENCE) begin
                        if (FENCE_AS_NOP) begin
                            state_q <= ST_WB;
                        end else begin
                            state_q <= ST_HALT;
                            cause_q <= CAUSE_FENCE;
                        end
                    end else begin
                        state_q <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    state_q <= (cls_q == CLS_LOAD || cls_q == CLS_STORE) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    if (bus.dmem_ready) begin
                        state_q <= ST_WB;
                    end else if (tmo_hit) begin
                        state_q <= ST_HALT;
                        cause_q <= CAUSE_TIMEOUT;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                ST_WB: begin
                    // A resumed halt passes through here once; its cause retires with it.
                    state_q <= ST_FETCH;
                    cause_q <= CAUSE_NONE;
                end
                ST_HALT: begin
                    // Illegal and timeout never match here, so they stay until reset.
                    if (bus.resume && (cause_q == CAUSE_ECALL || cause_q == CAUSE_EBREAK ||
                                       cause_q == CAUSE_FENCE)) begin
                        state_q <= ST_WB;
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    // Control word is live only in EXECUTE/MEM/WB; memory strobes belong to MEM,
    // the register write to WB. SYSTEM/FENCE classes carry RegWrite=0, so a
    // resumed WB only advances the PC.
    always_comb begin
        act_cw = CW_ZERO;
        if (state_q == ST_EXECUTE || state_q == ST_MEM || state_q == ST_WB) begin
            act_cw           = cw;
            act_cw.mem_read  = cw.mem_read  && (state_q == ST_MEM);
            act_cw.mem_write = cw.mem_write && (state_q == ST_MEM);
            act_cw.reg_write = cw.reg_write && (state_q == ST_WB);
        end
    end

    assign bus.imem_req   = (state_q == ST_FETCH);
    assign bus.ir_write   = (state_q == ST_FETCH) && bus.imem_ready;
    assign bus.dmem_req   = (state_q == ST_MEM);
    assign bus.pc_write   = (state_q == ST_WB);
    assign bus.halted     = (state_q == ST_HALT);
    assign bus.Branch     = act_cw.branch;
    assign bus.MemRead    = act_cw.mem_read;
    assign bus.MemWrite   = act_cw.mem_write;
    assign bus.ALUSrc     = act_cw.alu_src;
    assign bus.RegWrite   = act_cw.reg_write;
    assign bus.PCSelect   = act_cw.pc_select;
    assign bus.MemtoReg   = act_cw.mem_to_reg;
    assign bus.ALUOp      = act_cw.alu_op;
    assign bus.halt_cause = cause_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed test-plan scenarios then random instructions/latencies.
// Expected per-cycle outputs come from a per-instruction phase timeline built from the timing rules.
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
module tb_multicycle_control_fsm;

    localparam int TMO = 4;
    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_H = 5;
    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_LUI = 5, K_AUIPC = 6,
                   K_JAL = 7, K_JALR = 8, K_FENCE = 9, K_ECALL = 10, K_EBREAK = 11, K_ILL = 12;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req, dmem_req, ir_write, pc_write;
        logic       br, mr, mw, as, rw, ps;
        logic [2:0] m2r;
        logic [1:0] aop;
        logic       halted;
        logic [2:0] cause;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm #(.MEM_TIMEOUT(TMO), .FENCE_AS_NOP(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Datapath control word each instruction kind must present.
    function automatic obs_t cw_of(input int k);
        obs_t o = '0;
        case (k)
            K_R:     begin o.aop = 2'b10; o.rw = 1'b1; end
            K_I:     begin o.aop = 2'b10; o.as = 1'b1; o.rw = 1'b1; end
            K_LD:    begin o.as = 1'b1; o.mr = 1'b1; o.m2r = 3'b001; o.rw = 1'b1; end
            K_ST:    begin o.as = 1'b1; o.mw = 1'b1; end
            K_BR:    begin o.br = 1'b1; o.aop = 2'b01; end
            K_LUI:   begin o.m2r = 3'b010; o.aop = 2'b11; o.rw = 1'b1; end
            K_AUIPC: begin o.m2r = 3'b011; o.aop = 2'b11; o.rw = 1'b1; end
            K_JAL:   begin o.ps = 1'b1; o.m2r = 3'b100; o.aop = 2'b11; o.rw = 1'b1; end
            K_JALR:  begin o.as = 1'b1; o.ps = 1'b1; o.m2r = 3'b100; o.rw = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic obs_t expect_obs(input int ph, input int k, input int cause, input logic irdy);
        obs_t c = cw_of(k);
        obs_t o = '0;
        o.st = 3'(ph);
        case (ph)
            P_F: begin o.imem_req = 1'b1; o.ir_write = irdy; end
            P_E, P_M, P_W: begin
                o.br = c.br; o.as = c.as; o.ps = c.ps; o.m2r = c.m2r; o.aop = c.aop;
                if (ph == P_M) begin o.dmem_req = 1'b1; o.mr = c.mr; o.mw = c.mw; end
                if (ph == P_W) begin o.pc_write = 1'b1; o.rw = c.rw; end
            end
            P_H: o.halted = 1'b1;
            default: ;
        endcase
        o.cause = 3'(cause);
        return o;
    endfunction

    function automatic obs_t reset_obs();
        obs_t o = '0;
        o.imem_req = 1'b1;
        return o;
    endfunction

    function automatic obs_t capture();
        obs_t o;
        o.st = bus.state;       o.imem_req = bus.imem_req; o.dmem_req = bus.dmem_req;
        o.ir_write = bus.ir_write; o.pc_write = bus.pc_write;
        o.br = bus.Branch;      o.mr = bus.MemRead;  o.mw = bus.MemWrite;
        o.as = bus.ALUSrc;      o.rw = bus.RegWrite; o.ps = bus.PCSelect;
        o.m2r = bus.MemtoReg;   o.aop = bus.ALUOp;
        o.halted = bus.halted;  o.cause = bus.halt_cause;
        return o;
    endfunction

    function automatic logic [31:0] make_instr(input int k);
        logic [31:0] w = $urandom;
        w[1:0] = 2'b11;
        case (k)
            K_R:     w[6:2] = 5'b01100;
            K_I:     w[6:2] = 5'b00100;
            K_LD:    w[6:2] = 5'b00000;
            K_ST:    w[6:2] = 5'b01000;
            K_BR:    w[6:2] = 5'b11000;
            K_LUI:   w[6:2] = 5'b01101;
            K_AUIPC: w[6:2] = 5'b00101;
            K_JAL:   w[6:2] = 5'b11011;
            K_JALR:  w[6:2] = 5'b11001;
            K_FENCE: w[6:2] = 5'b00011;
            K_ECALL:  begin w[6:2] = 5'b11100; w[20] = 1'b0; end
            K_EBREAK: begin w[6:2] = 5'b11100; w[20] = 1'b1; end
            default: begin
                case ($urandom_range(0, 4))
                    0:       w[6:2] = 5'b11111;
                    1:       w[6:2] = 5'b00010;
                    2:       w[6:2] = 5'b10100;
                    3:       w[6:2] = 5'b01011;
                    default: w[1:0] = 2'($urandom_range(0, 2));
                endcase
            end
        endcase
        return w;
    endfunction

    task automatic check(input obs_t exp_in, input string tag, input bit mask_cause);
        obs_t act = capture();
        obs_t exp = exp_in;
        if (mask_cause) begin
            act.cause = '0;
            exp.cause = '0;
        end
        checks++;
        assert (act === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, act, exp);
    endtask

    task automatic step(input logic ir, input logic dr, input logic rs,
                        input obs_t exp, input string tag, input bit mask_cause);
        @(negedge clk);
        bus.imem_ready = ir;
        bus.dmem_ready = dr;
        bus.resume     = rs;
        #1 check(exp, tag, mask_cause);
    endtask

    // One-cycle reset with resume held high through the release.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.resume = 1'b1;
        #1 check(reset_obs(), {tag, "/in_reset"}, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check(reset_obs(), {tag, "/released"}, 1'b0);
    endtask

    // Builds the expected phase sequence of one instruction, then plays it.
    task automatic run_instr(input int k, input logic [31:0] ins, input int idly,
                             input int ddly, input string tag);
        int   ph[$];
        int   hc   = 0;
        int   fcnt = 0;
        int   dcnt = 0;
        logic ir, dr, rs;
        if (idly >= TMO) begin
            for (int i = 0; i < TMO; i++) ph.push_back(P_F);
            ph.push_back(P_H); hc = 5;
        end else begin
            for (int i = 0; i <= idly; i++) ph.push_back(P_F);
            ph.push_back(P_D);
            case (k)
                K_ILL:    begin ph.push_back(P_H); hc = 4; end
                K_ECALL:  begin ph.push_back(P_H); hc = 1; end
                K_EBREAK: begin ph.push_back(P_H); hc = 2; end
                K_FENCE:  ph.push_back(P_W);
                default: begin
                    ph.push_back(P_E);
                    if (k == K_LD || k == K_ST) begin
                        if (ddly >= TMO) begin
                            for (int i = 0; i < TMO; i++) ph.push_back(P_M);
                            ph.push_back(P_H); hc = 5;
                        end else begin
                            for (int i = 0; i <= ddly; i++) ph.push_back(P_M);
                        end
                    end
                    if (hc == 0) ph.push_back(P_W);
                end
            endcase
        end
        bus.instr = ins;
        foreach (ph[i]) begin
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            if (ph[i] == P_F) begin ir = (fcnt == idly); fcnt++; end
            if (ph[i] == P_M) begin dr = (dcnt == ddly); dcnt++; end
            if (ph[i] == P_H) rs = 1'b0;
            step(ir, dr, rs, expect_obs(ph[i], k, (ph[i] == P_H) ? hc : 0, ir),
                 $sformatf("%s/c%0d", tag, i), ph[i] == P_W);
        end
        if (hc >= 4) begin
            for (int i = 0; i < 2; i++)
                step(1'b0, 1'b0, 1'b1, expect_obs(P_H, k, hc, 1'b0), {tag, "/sticky"}, 1'b0);
            do_reset(tag);
        end else if (hc != 0) begin
            step(1'b0, 1'b0, 1'b0, expect_obs(P_H, k, hc, 1'b0), {tag, "/halt_wait"}, 1'b0);
            step(1'b0, 1'b0, 1'b1, expect_obs(P_H, k, hc, 1'b0), {tag, "/halt_resume"}, 1'b0);
            step(1'b0, 1'b0, 1'b0, expect_obs(P_W, k, 0, 1'b0), {tag, "/resume_wb"}, 1'b1);
        end
    endtask

    initial begin
        int k, idly, ddly;
        bus.instr = '0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.resume = 1'b1;
        rst_n = 1'b0;
        #1 check(reset_obs(), "reset", 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check(reset_obs(), "reset_release_resume_high", 1'b0);

        run_instr(K_R,      32'h003100B3, 0, 0, "add");
        run_instr(K_LD,     32'h0000A103, 0, 3, "lw_wait3");
        run_instr(K_R,      32'h003100B3, 4, 0, "imem_timeout");
        run_instr(K_EBREAK, 32'h00100073, 0, 0, "ebreak");
        run_instr(K_ECALL,  32'h00000073, 1, 0, "ecall");
        run_instr(K_ILL,    32'h0000007F, 0, 0, "illegal");
        run_instr(K_FENCE,  32'h0000000F, 2, 0, "fence_nop");
        run_instr(K_ST,     32'h00112023, 0, 4, "sw_dmem_timeout");
        run_instr(K_BR,     32'h00208463, 3, 0, "beq_imem_edge");

        // JAL interrupted by reset in EXECUTE
        bus.instr = 32'h008000EF;
        step(1'b1, 1'b0, 1'b0, expect_obs(P_F, K_JAL, 0, 1'b1), "jal/fetch", 1'b0);
        step(1'b0, 1'b1, 1'b0, expect_obs(P_D, K_JAL, 0, 1'b0), "jal/decode", 1'b0);
        step(1'b0, 1'b0, 1'b0, expect_obs(P_E, K_JAL, 0, 1'b0), "jal/execute", 1'b0);
        #1 rst_n = 1'b0;
        #1 check(reset_obs(), "jal/async_reset", 1'b0);
        @(posedge clk);
        #1 check(reset_obs(), "jal/reset_held", 1'b0);
        rst_n = 1'b1;
        #1 check(reset_obs(), "jal/released", 1'b0);

        for (int n = 0; n < 150; n++) begin
            k    = $urandom_range(0, 12);
            idly = $urandom_range(0, 9);
            if (idly > 5) idly = 0;
            ddly = $urandom_range(0, 4);
            run_instr(k, make_instr(k), idly, ddly, $sformatf("rnd%0d_k%0d", n, k));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
